// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter: op encodings, FSM states and default widths.
package shift_pkg;

    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_SHAMT_W = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_stage.sv
// One power-of-two shift stage (amount 2^idx); the fill for the vacated top bits is zero,
// the operand sign, or the bits rotated out of the bottom.
module shift_stage
    import shift_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int SHAMT_W = DEFAULT_SHAMT_W,
    parameter int IDX_W   = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1
) (
    input  logic [DATA_W-1:0] data,
    input  logic [IDX_W-1:0]  idx,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] result
);

    logic [SHAMT_W:0]    k;
    logic [DATA_W-1:0]   right;
    logic [DATA_W-1:0]   fill_mask;
    logic [DATA_W-1:0]   wrapped;

    // k never exceeds DATA_W/2, so the wrap distance DATA_W-k is always a legal shift
    assign k         = (SHAMT_W+1)'(1) << idx;
    assign right     = data >> k;
    assign fill_mask = ~({DATA_W{1'b1}} >> k);
    assign wrapped   = data << ((SHAMT_W+1)'(DATA_W) - k);

    always_comb begin
        result = '0;
        case (op)
            OP_SLL:  result = data << k;
            OP_SRL:  result = right;
            OP_SRA:  result = right | (data[DATA_W-1] ? fill_mask : '0);
            OP_ROR:  result = right | wrapped;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative shifter controller: drives one shift_stage over several cycles.
// Optional macro SHIFT_SKIP_EN visits only the set bits of the shift amount.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               busy
);

    localparam int IDX_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [1:0]         op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  stage_out;

    shift_stage #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W),
        .IDX_W   (IDX_W)
    ) u_stage (
        .data   (data_q),
        .idx    (idx_q),
        .op     (op_q),
        .result (stage_out)
    );

`ifdef SHIFT_SKIP_EN
    logic [SHAMT_W-1:0] remaining;

    function automatic logic [IDX_W-1:0] top_bit(input logic [SHAMT_W-1:0] v);
        top_bit = '0;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (v[i]) top_bit = IDX_W'(i);
        end
    endfunction

    // shamt bits strictly below the stage being processed this cycle
    always_comb begin
        remaining = '0;
        for (int i = 0; i < SHAMT_W; i++) begin
            remaining[i] = shamt_q[i] && (i < int'(idx_q));
        end
    end
`endif

    // Handshakes: a transfer happens on a rising edge where valid && ready; in_ready is high
    // only in IDLE, and out_valid/out_data hold steady in DONE until out_ready is seen.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    shamt_d = in_shamt;
                    op_d    = in_op;
`ifdef SHIFT_SKIP_EN
                    idx_d   = top_bit(in_shamt);
                    state_d = (in_shamt == '0) ? DONE : SHIFT;
`else
                    idx_d   = IDX_W'(SHAMT_W - 1);
                    state_d = SHIFT;
`endif
                end
            end
            SHIFT: begin
                if (shamt_q[idx_q]) data_d = stage_out;
`ifdef SHIFT_SKIP_EN
                if (remaining == '0) state_d = DONE;
                else                 idx_d   = top_bit(remaining);
`else
                if (idx_q == '0) state_d = DONE;
                else             idx_d   = idx_q - IDX_W'(1);
`endif
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = (state_q == DONE) ? data_q : '0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer; expected results and latencies go through a scoreboard.
module tb_shift_sequencer;
    import shift_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          checks;
    int          errors;

    shift_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                          input logic [1:0] op);
        logic signed [31:0] sd;
        sd = d;
        case (op)
            OP_SLL:  model = d << s;
            OP_SRL:  model = d >> s;
            OP_SRA:  model = sd >>> s;
            default: model = (d >> s) | (d << (6'd32 - {1'b0, s}));
        endcase
    endfunction

    function automatic int exp_lat(input logic [4:0] s);
`ifdef SHIFT_SKIP_EN
        exp_lat = $countones(s);
`else
        exp_lat = 5;
`endif
    endfunction

    // driver: issue one request, push its expectation, wait (bounded) for out_valid
    task automatic run_txn(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                           input logic [31:0] exp, output int lat, output logic [31:0] got);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_op    = op;
        exp_q.push_back(exp);
        lat_q.push_back(exp_lat(s));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_shamt = 5'($urandom_range(0, 31));
        in_op    = 2'($urandom_range(0, 3));
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = out_data;
    endtask

    task automatic release_txn();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_sll();
        int lat; logic [31:0] got, exp; int el;
        run_txn(32'h0000_0001, 5'd31, OP_SLL, 32'h8000_0000, lat, got);
        exp = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (lat !== el) begin errors++; $display("FAIL sll_latency: got %0d expected %0d", lat, el); end
        checks++; if (got !== exp) begin errors++; $display("FAIL sll_data: got %h expected %h", got, exp); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sll_in_ready_done: got %b expected 0", in_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sll_busy_done: got %b expected 1", busy); end
        release_txn();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sll_out_valid_drop: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sll_in_ready_idle: got %b expected 1", in_ready); end
    endtask

    task automatic test_sra();
        int lat; logic [31:0] got, exp; int el;
        run_txn(32'h8000_0000, 5'd4, OP_SRA, 32'hF800_0000, lat, got);
        exp = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (lat !== el) begin errors++; $display("FAIL sra_latency: got %0d expected %0d", lat, el); end
        checks++; if (got !== exp) begin errors++; $display("FAIL sra_data: got %h expected %h", got, exp); end
        release_txn();
    endtask

    task automatic test_ror();
        int lat; logic [31:0] got, exp; int el;
        run_txn(32'h1234_5678, 5'd8, OP_ROR, 32'h7812_3456, lat, got);
        exp = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (lat !== el) begin errors++; $display("FAIL ror8_latency: got %0d expected %0d", lat, el); end
        checks++; if (got !== exp) begin errors++; $display("FAIL ror8_data: got %h expected %h", got, exp); end
        release_txn();
        run_txn(32'h8000_0001, 5'd1, OP_ROR, 32'hC000_0000, lat, got);
        exp = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (lat !== el) begin errors++; $display("FAIL ror1_latency: got %0d expected %0d", lat, el); end
        checks++; if (got !== exp) begin errors++; $display("FAIL ror1_data: got %h expected %h", got, exp); end
        release_txn();
    endtask

    task automatic test_srl_zero();
        int lat; logic [31:0] got, exp; int el;
        run_txn(32'hF000_000F, 5'd0, OP_SRL, 32'hF000_000F, lat, got);
        exp = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (lat !== el) begin errors++; $display("FAIL srl0_latency: got %0d expected %0d", lat, el); end
        checks++; if (got !== exp) begin errors++; $display("FAIL srl0_data: got %h expected %h", got, exp); end
        release_txn();
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] got, exp; int el;
        run_txn(32'hA5A5_0F0F, 5'd4, OP_SRL, 32'h0A5A_50F0, lat, got);
        exp = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (lat !== el) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, el); end
        checks++; if (got !== exp) begin errors++; $display("FAIL bp_data: got %h expected %h", got, exp); end
        // offer the next request while the first result is stalled
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h0000_00FF;
        in_shamt = 5'd8;
        in_op    = OP_SLL;
        exp_q.push_back(32'h0000_FF00);
        lat_q.push_back(exp_lat(5'd8));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++; if (out_data !== exp) begin errors++; $display("FAIL bp_hold_data: got %h expected %h", out_data, exp); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready: got %b expected 0", in_ready); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_hold_busy: got %b expected 1", busy); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept: got busy %b expected 1", busy); end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        exp = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (lat !== el) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, el); end
        checks++; if (out_data !== exp) begin errors++; $display("FAIL b2b_data: got %h expected %h", out_data, exp); end
        release_txn();
    endtask

    task automatic test_reset_mid_shift();
        int lat; logic [31:0] got, exp; int el; int seen;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hFFFF_0000;
        in_shamt = 5'd7;
        in_op    = OP_SRL;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_in_shift: got busy %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_mid_out_data: got %h expected 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_discard: got %0d out_valid cycles expected 0", seen); end
        run_txn(32'h0000_0003, 5'd2, OP_SLL, 32'h0000_000C, lat, got);
        exp = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (lat !== el) begin errors++; $display("FAIL rst_after_latency: got %0d expected %0d", lat, el); end
        checks++; if (got !== exp) begin errors++; $display("FAIL rst_after_data: got %h expected %h", got, exp); end
        release_txn();
    endtask

    task automatic test_random();
        int lat; logic [31:0] got, exp, d; int el;
        logic [4:0] s; logic [1:0] op;
        for (int t = 0; t < 12; t++) begin
            d  = $urandom;
            s  = 5'($urandom_range(0, 31));
            op = 2'($urandom_range(0, 3));
            run_txn(d, s, op, model(d, s, op), lat, got);
            exp = exp_q.pop_front(); el = lat_q.pop_front();
            checks++; if (lat !== el) begin errors++; $display("FAIL rand_latency op=%0d s=%0d: got %0d expected %0d", op, s, lat, el); end
            checks++; if (got !== exp) begin errors++; $display("FAIL rand_data op=%0d s=%0d d=%h: got %h expected %h", op, s, d, got, exp); end
            release_txn();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sll();
        test_sra();
        test_ror();
        test_srl_zero();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Iterative 32-bit shifter controller.
- Drives one variable-amount shift stage over multiple cycles. On each cycle the stage applies one power-of-two amount (16, 8, 4, 2, 1), selected by the bits of the shift amount.
- Replaces a full 5-layer combinational barrel shifter wherever area matters more than latency.
- Sits between the ALU issue logic (request side) and the writeback path (response side), with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 32, datapath width; must be a power of two, minimum 8.
- SHAMT_W, 5, shift-amount width; equals log2(DATA_W).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  sequencer can accept a request.
- in_data  in  DATA_W  operand.
- in_shamt  in  SHAMT_W  shift amount.
- in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  result.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - state = IDLE; data, shamt, op and stage index registers = 0.
  - in_ready = 1, out_valid = 0, out_data = 0, busy = 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_data, in_shamt, in_op; stage index = SHAMT_W-1.
  - Go to SHIFT, except that with SHIFT_SKIP_EN and in_shamt == 0 the next state is DONE directly.
- SHIFT, one stage per cycle, amount k = 2^idx:
  - If shamt[idx] = 1, the data register takes the stage result; otherwise it holds.
  - SLL: left shift by k, zero fill.
  - SRL: right shift by k, zero fill.
  - SRA: right shift by k, fill with the latched operand MSB (sign).
  - ROR: rotate right by k; the low k bits wrap into the top.
  - After processing idx 0, go to DONE. Otherwise decrement idx.
- DONE:
  - out_valid = 1; out_data = the data register.
  - out_data is stable while out_valid & !out_ready.
  - On out_ready, go to IDLE; out_valid drops on the next cycle.
- in_ready = (state == IDLE) only. No request is accepted in DONE, even in a cycle where out_ready is high, so back-to-back requests cost 1 bubble cycle.
- Latency without SHIFT_SKIP_EN: out_valid asserts exactly 5 rising edges after the accepting edge, for every shamt.
- in_shamt values ≥ DATA_W cannot occur (the field is SHAMT_W bits).
- In ROR, DATA_W-bit wrap-around is exact for every shamt.
- rst_n asserted mid-SHIFT or mid-DONE: immediate return to the reset values; the in-flight result is discarded and no out_valid is emitted.
- Inputs are ignored outside IDLE; in_data may change freely while busy.

Optional Feature:
- Macro: SHIFT_SKIP_EN.
- Defined:
  - SHIFT visits only the set bits of shamt. idx jumps to the next lower set bit (priority encode of the remaining bits). When no set bits remain, go to DONE.
  - Latency = popcount(shamt) edges after acceptance.
  - shamt == 0 goes IDLE → DONE at the accepting edge, so out_valid is high in the following cycle.
- Undefined: fixed 5-cycle SHIFT, as described under Behaviour.

Decomposition:
- Package shift_pkg holds:
  - the op encoding constants OP_SLL, OP_SRL, OP_SRA, OP_ROR;
  - the state encoding for IDLE, SHIFT, DONE;
  - default DATA_W and SHAMT_W.
- Sub-module shift_stage (combinational): inputs data, k-select idx, op; output is the single-stage result, with the fill bit chosen from zero, sign or the wrapped bits.
- The sequencer instantiates shift_stage exactly once.

Test Plan:
- SLL, in_data 0x0000_0001, shamt 31 → out_data 0x8000_0000. out_valid 5 edges after acceptance, in both builds (popcount = 5).
- SRA, in_data 0x8000_0000, shamt 4 → out_data 0xF800_0000. Latency 5 without the macro, 1 with SHIFT_SKIP_EN.
- ROR, in_data 0x1234_5678, shamt 8 → 0x7812_3456. Then ROR 0x8000_0001, shamt 1 → 0xC000_0000.
- SRL, in_data 0xF000_000F, shamt 0 → 0xF000_000F. Latency 5 without the macro, 0 edges with SHIFT_SKIP_EN (out_valid in the cycle after acceptance).
- Backpressure: hold out_ready = 0 for 3 cycles in DONE → out_data stable, in_ready = 0, busy = 1. Raise out_ready → IDLE next cycle, and a new request is accepted the cycle after.
- Reset mid-SHIFT: pull rst_n low on the 2nd SHIFT cycle → out_valid = 0, in_ready = 1, out_data = 0 immediately. A subsequent SLL 0x3, shamt 2 → 0xC.
